// File: rtl/game_sequencer.sv
// Tetris play controller: owns the locked field and the active piece, and
// sequences spawn, gravity/player moves, lock, merge and line clean.
package game_pkg;
    localparam int FIELD_ROWS = 20;
    localparam int FIELD_COLS = 10;
    localparam int CELL_W     = 3;

    typedef struct packed {
        logic [CELL_W-1:0] data;
    } cell_t;

    typedef cell_t [FIELD_COLS-1:0] row_t;
    typedef row_t  [FIELD_ROWS-1:0] field_t;

    typedef struct packed {
        logic signed [4:0] x;
        logic        [4:0] y;
    } coord_t;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] tetromino;
        logic [1:0]  rotation;
        coord_t      coordinate;
    } tetromino_ctrl;
endpackage

// state     | meaning
// IDLE      | no game running, waiting for start
// SPAWN     | latch next piece into cand at the spawn point
// SPAWN_CHK | spawn candidate checked; fail ends the game
// READY     | piece in play, servicing gravity or one player command
// MOVE_CHK  | single-step candidate checked; downward fail locks
// HARD_CHK  | hard drop descending one row per cycle until blocked
// LOCK      | merge active piece into the field
// CLEAN     | waiting on clean_field to collapse full rows
// OVER      | spawn blocked; everything frozen until start
module game_sequencer
    import game_pkg::*;
#(
    parameter int SPAWN_X = 3,
    parameter int SPAWN_Y = 0,
    parameter int LINES_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               drop_tick,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd,
    output logic               cmd_ready,
    input  tetromino_ctrl      spawn_piece,
    output logic               spawn_ack,
    output tetromino_ctrl      chk_t,
    output field_t             chk_f,
    input  logic               chk_ok,
    output tetromino_ctrl      cur,
    output field_t             field,
    input  field_t             merge_f,
    output logic               clean_enable,
    input  field_t             clean_f,
    input  logic [2:0]         clean_lines,
    input  logic               clean_done,
    output logic [LINES_W-1:0] lines_total,
    output logic               game_over,
    output logic               busy
);

    typedef enum logic [3:0] {
        IDLE, SPAWN, SPAWN_CHK, READY, MOVE_CHK, HARD_CHK, LOCK, CLEAN, OVER
    } state_t;

    typedef enum logic [1:0] {
        MV_GRAVITY, MV_SOFT, MV_SIDE
    } move_kind_t;

    state_t             state, state_n;
    tetromino_ctrl      cur_q, cur_n;
    tetromino_ctrl      cand_q, cand_n;
    field_t             field_q, field_n;
    move_kind_t         kind_q, kind_n;
    logic [LINES_W-1:0] lines_q, lines_n;
    logic [LINES_W:0]   lines_sum;
    logic               pend_q, pend_n;
    logic               over_q, over_n;
    logic               clean_en_q, clean_en_n;
    logic               ack_q, ack_n;
    logic               tick_due;
    logic               tick_held;

    function automatic tetromino_ctrl nudge(input tetromino_ctrl p,
                                            input logic [4:0]    dx,
                                            input logic [4:0]    dy,
                                            input logic [1:0]    dr);
        tetromino_ctrl q;
        q                = p;
        q.coordinate.x   = p.coordinate.x + dx;
        q.coordinate.y   = p.coordinate.y + dy;
        q.rotation       = p.rotation + dr;
        return q;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cur_q      <= '0;
            cand_q     <= '0;
            field_q    <= '1;
            kind_q     <= MV_GRAVITY;
            lines_q    <= '0;
            pend_q     <= 1'b0;
            over_q     <= 1'b0;
            clean_en_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state      <= state_n;
            cur_q      <= cur_n;
            cand_q     <= cand_n;
            field_q    <= field_n;
            kind_q     <= kind_n;
            lines_q    <= lines_n;
            pend_q     <= pend_n;
            over_q     <= over_n;
            clean_en_q <= clean_en_n;
            ack_q      <= ack_n;
        end
    end

    assign tick_due  = drop_tick | pend_q;
    assign tick_held = drop_tick & (state != IDLE) & (state != OVER) & (state != READY);
    assign lines_sum = {1'b0, lines_q} + {{(LINES_W-2){1'b0}}, clean_lines};

    always_comb begin
        state_n    = state;
        cur_n      = cur_q;
        cand_n     = cand_q;
        field_n    = field_q;
        kind_n     = kind_q;
        lines_n    = lines_q;
        pend_n     = pend_q | tick_held;
        over_n     = over_q;
        clean_en_n = clean_en_q;
        ack_n      = 1'b0;

        if (start) begin
            field_n    = '1;
            lines_n    = '0;
            pend_n     = 1'b0;
            clean_en_n = 1'b0;
            over_n     = 1'b0;
            state_n    = SPAWN;
        end else begin
            case (state)
                SPAWN: begin
                    cand_n              = spawn_piece;
                    cand_n.rotation     = 2'd0;
                    cand_n.coordinate.x = 5'(SPAWN_X);
                    cand_n.coordinate.y = 5'(SPAWN_Y);
                    ack_n               = 1'b1;
                    state_n             = SPAWN_CHK;
                end
                SPAWN_CHK: begin
                    if (chk_ok) begin
                        cur_n   = cand_q;
                        state_n = READY;
                    end else begin
                        over_n  = 1'b1;
                        state_n = OVER;
                    end
                end
                READY: begin
                    // Gravity wins over a simultaneous command; cmd_ready is low then.
                    if (tick_due) begin
                        cand_n  = nudge(cur_q, 5'd0, 5'd1, 2'd0);
                        kind_n  = MV_GRAVITY;
                        pend_n  = 1'b0;
                        state_n = MOVE_CHK;
                    end else if (cmd_valid && cmd_ready) begin
                        case (cmd)
                            3'd0: begin
                                cand_n  = nudge(cur_q, 5'h1F, 5'd0, 2'd0);
                                kind_n  = MV_SIDE;
                                state_n = MOVE_CHK;
                            end
                            3'd1: begin
                                cand_n  = nudge(cur_q, 5'd1, 5'd0, 2'd0);
                                kind_n  = MV_SIDE;
                                state_n = MOVE_CHK;
                            end
                            3'd2: begin
                                cand_n  = nudge(cur_q, 5'd0, 5'd0, 2'd1);
                                kind_n  = MV_SIDE;
                                state_n = MOVE_CHK;
                            end
                            3'd3: begin
                                cand_n  = nudge(cur_q, 5'd0, 5'd1, 2'd0);
                                kind_n  = MV_SOFT;
                                state_n = MOVE_CHK;
                            end
                            3'd4: begin
                                cand_n  = nudge(cur_q, 5'd0, 5'd1, 2'd0);
                                state_n = HARD_CHK;
                            end
                            default: ;
                        endcase
                    end
                end
                MOVE_CHK: begin
                    if (chk_ok) begin
                        cur_n   = cand_q;
                        state_n = READY;
                    end else if (kind_q != MV_SIDE) begin
                        state_n = LOCK;
                    end else begin
                        state_n = READY;
                    end
                end
                HARD_CHK: begin
                    if (chk_ok) begin
                        cur_n   = cand_q;
                        cand_n  = nudge(cand_q, 5'd0, 5'd1, 2'd0);
                    end else begin
                        state_n = LOCK;
                    end
                end
                LOCK: begin
                    field_n    = merge_f;
                    clean_en_n = 1'b1;
                    state_n    = CLEAN;
                end
                CLEAN: begin
                    if (clean_done) begin
                        field_n    = clean_f;
                        lines_n    = lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
                        clean_en_n = 1'b0;
                        state_n    = SPAWN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready    = (state == READY) & ~drop_tick & ~pend_q;
    assign busy         = (state != READY) && (state != IDLE);
    assign cur          = cur_q;
    assign chk_t        = cand_q;
    assign field        = field_q;
    assign chk_f        = field_q;
    assign spawn_ack    = ack_q;
    assign clean_enable = clean_en_q;
    assign lines_total  = lines_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed move table, hand-written corner sequences,
// then random stimulus against a transaction-level reference model.
module tb_game_sequencer;
    import game_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, drop_tick, cmd_valid, chk_ok, clean_done;
    logic [2:0]    cmd, clean_lines;
    tetromino_ctrl spawn_piece;
    field_t        merge_f, clean_f;

    logic          cmd_ready, spawn_ack, clean_enable, game_over, busy;
    tetromino_ctrl chk_t, cur;
    field_t        chk_f, field;
    logic [15:0]   lines_total;

    logic          s_ready, s_ack, s_ce, s_over, s_busy;
    tetromino_ctrl s_chk_t, s_cur;
    field_t        s_chk_f, s_field;
    logic [2:0]    s_lines;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    game_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .drop_tick(drop_tick),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .spawn_piece(spawn_piece), .spawn_ack(spawn_ack), .chk_t(chk_t), .chk_f(chk_f),
        .chk_ok(chk_ok), .cur(cur), .field(field), .merge_f(merge_f),
        .clean_enable(clean_enable), .clean_f(clean_f), .clean_lines(clean_lines),
        .clean_done(clean_done), .lines_total(lines_total), .game_over(game_over), .busy(busy)
    );

    // Narrow counter copy sharing all stimulus; exercises saturation quickly.
    game_sequencer #(.LINES_W(3)) u_small (
        .clk(clk), .rst(rst), .start(start), .drop_tick(drop_tick),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(s_ready),
        .spawn_piece(spawn_piece), .spawn_ack(s_ack), .chk_t(s_chk_t), .chk_f(s_chk_f),
        .chk_ok(chk_ok), .cur(s_cur), .field(s_field), .merge_f(merge_f),
        .clean_enable(s_ce), .clean_f(clean_f), .clean_lines(clean_lines),
        .clean_done(clean_done), .lines_total(s_lines), .game_over(s_over), .busy(s_busy)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_num(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_piece(input string name, input tetromino_ctrl act, input tetromino_ctrl exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_field(input string name, input field_t act, input field_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic field_t rand_field();
        field_t      f;
        logic [31:0] w;
        for (int r = 0; r < FIELD_ROWS; r++) begin
            w    = $urandom;
            f[r] = w[FIELD_COLS*CELL_W-1:0];
        end
        return f;
    endfunction

    function automatic tetromino_ctrl spawned(input tetromino_ctrl raw);
        tetromino_ctrl p;
        p              = raw;
        p.rotation     = 2'd0;
        p.coordinate.x = 5'sd3;
        p.coordinate.y = 5'd0;
        return p;
    endfunction

    function automatic tetromino_ctrl shift(input tetromino_ctrl p, input int dx, input int dy, input int dr);
        tetromino_ctrl q;
        q              = p;
        q.coordinate.x = 5'(int'(p.coordinate.x) + dx);
        q.coordinate.y = 5'(int'(p.coordinate.y) + dy);
        q.rotation     = 2'((int'(p.rotation) + dr) % 4);
        return q;
    endfunction

    task automatic clear_inputs();
        start = 0; drop_tick = 0; cmd_valid = 0; cmd = 0; chk_ok = 0;
        clean_done = 0; clean_lines = 0;
    endtask

    // From SPAWN: spawn ok, gravity fails, lock with m, arrive in CLEAN.
    task automatic go_clean(input field_t m);
        merge_f = m;
        chk_ok = 1; step(); step();
        drop_tick = 1; chk_ok = 0; step();
        drop_tick = 0; step(); step();
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_SPAWN, P_SCHK, P_READY, P_MCHK, P_HCHK, P_LOCK, P_CLEAN, P_OVER} phase_t;
    phase_t        ph;
    tetromino_ctrl m_cur, m_cand;
    field_t        m_field;
    int            m_lines;
    logic          m_over, m_ce, m_ack, m_pend, m_lockable;

    task automatic model_reset();
        ph = P_IDLE; m_cur = '0; m_cand = '0; m_field = '1; m_lines = 0;
        m_over = 0; m_ce = 0; m_ack = 0; m_pend = 0; m_lockable = 0;
    endtask

    task automatic model_step();
        logic tick_now;
        tick_now = drop_tick || m_pend;
        m_ack    = 0;
        if (start) begin
            m_field = '1; m_lines = 0; m_pend = 0; m_ce = 0; m_over = 0;
            ph = P_SPAWN;
            return;
        end
        if (drop_tick && ph != P_IDLE && ph != P_OVER && ph != P_READY) m_pend = 1;
        case (ph)
            P_SPAWN: begin m_cand = spawned(spawn_piece); m_ack = 1; ph = P_SCHK; end
            P_SCHK: begin
                if (chk_ok) begin m_cur = m_cand; ph = P_READY; end
                else begin m_over = 1; ph = P_OVER; end
            end
            P_READY: begin
                if (tick_now) begin
                    m_cand = shift(m_cur, 0, 1, 0); m_lockable = 1; m_pend = 0; ph = P_MCHK;
                end else if (cmd_valid) begin
                    case (cmd)
                        3'd0: begin m_cand = shift(m_cur, -1, 0, 0); m_lockable = 0; ph = P_MCHK; end
                        3'd1: begin m_cand = shift(m_cur,  1, 0, 0); m_lockable = 0; ph = P_MCHK; end
                        3'd2: begin m_cand = shift(m_cur,  0, 0, 1); m_lockable = 0; ph = P_MCHK; end
                        3'd3: begin m_cand = shift(m_cur,  0, 1, 0); m_lockable = 1; ph = P_MCHK; end
                        3'd4: begin m_cand = shift(m_cur,  0, 1, 0); ph = P_HCHK; end
                        default: ;
                    endcase
                end
            end
            P_MCHK: begin
                if (chk_ok) begin m_cur = m_cand; ph = P_READY; end
                else ph = m_lockable ? P_LOCK : P_READY;
            end
            P_HCHK: begin
                if (chk_ok) begin m_cur = m_cand; m_cand = shift(m_cand, 0, 1, 0); end
                else ph = P_LOCK;
            end
            P_LOCK: begin m_field = merge_f; m_ce = 1; ph = P_CLEAN; end
            P_CLEAN: begin
                if (clean_done) begin
                    m_field = clean_f; m_lines += int'(clean_lines); m_ce = 0; ph = P_SPAWN;
                end
            end
            default: ;
        endcase
    endtask

    typedef struct {
        logic [2:0] cmd;
        logic       ok;
        int         x;
        int         y;
        int         rot;
    } vec_t;

    initial begin
        #50000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          vecs[12];
        tetromino_ctrl t_raw, t2_raw, exp1, exp2;
        field_t        p1, p2, p3, p4;
        logic [31:0]   w;

        vecs[0]  = '{3'd0, 1'b1, 2, 0, 0};
        vecs[1]  = '{3'd0, 1'b0, 2, 0, 0};
        vecs[2]  = '{3'd1, 1'b1, 3, 0, 0};
        vecs[3]  = '{3'd1, 1'b0, 3, 0, 0};
        vecs[4]  = '{3'd2, 1'b1, 3, 0, 1};
        vecs[5]  = '{3'd2, 1'b1, 3, 0, 2};
        vecs[6]  = '{3'd2, 1'b1, 3, 0, 3};
        vecs[7]  = '{3'd2, 1'b1, 3, 0, 0};
        vecs[8]  = '{3'd2, 1'b0, 3, 0, 0};
        vecs[9]  = '{3'd3, 1'b1, 3, 1, 0};
        vecs[10] = '{3'd5, 1'b1, 3, 1, 0};
        vecs[11] = '{3'd7, 1'b0, 3, 1, 0};

        t_raw = '0;
        t_raw.idx = 3'd2; t_raw.tetromino = 16'h4E00; t_raw.rotation = 2'd2;
        t_raw.coordinate.x = 5'sd7; t_raw.coordinate.y = 5'd9;
        t2_raw = t_raw;
        t2_raw.idx = 3'd5; t2_raw.tetromino = 16'h6600; t2_raw.rotation = 2'd1;
        exp1 = spawned(t_raw);
        exp2 = spawned(t2_raw);
        p1 = rand_field(); p2 = rand_field(); p3 = rand_field(); p4 = rand_field();

        rst = 0;
        clear_inputs();
        spawn_piece = t_raw; merge_f = '1; clean_f = '1;
        repeat (2) @(posedge clk);
        #1;
        check_piece("reset cur", cur, '0);
        check_piece("reset chk_t", chk_t, '0);
        check_field("reset field", field, '1);
        check_num("reset lines", int'(lines_total), 0);
        check_bit("reset game_over", game_over, 0);
        check_bit("reset clean_enable", clean_enable, 0);
        check_bit("reset spawn_ack", spawn_ack, 0);
        check_bit("reset cmd_ready", cmd_ready, 0);
        check_bit("reset busy", busy, 0);
        rst = 1;
        step();
        check_bit("idle busy", busy, 0);

        // spawn
        start = 1; step(); start = 0;
        check_bit("spawn state busy", busy, 1);
        chk_ok = 1; step();
        check_bit("spawn_ack pulse", spawn_ack, 1);
        check_piece("spawn cand", chk_t, exp1);
        step();
        check_piece("spawn cur", cur, exp1);
        check_bit("spawn_ack drop", spawn_ack, 0);
        check_bit("spawn ready", cmd_ready, 1);
        check_bit("spawn game_over", game_over, 0);

        // move table
        for (int i = 0; i < 12; i++) begin
            cmd_valid = 1; cmd = vecs[i].cmd; chk_ok = vecs[i].ok;
            #1;
            check_bit($sformatf("vec%0d cmd_ready", i), cmd_ready, 1);
            step();
            cmd_valid = 0;
            step();
            check_num($sformatf("vec%0d x", i), int'(cur.coordinate.x), vecs[i].x);
            check_num($sformatf("vec%0d y", i), int'(cur.coordinate.y), vecs[i].y);
            check_num($sformatf("vec%0d rot", i), int'(cur.rotation), vecs[i].rot);
            check_bit($sformatf("vec%0d busy", i), busy, 0);
        end

        // tick beats command; gravity failure locks
        drop_tick = 1; cmd_valid = 1; cmd = 3'd0; chk_ok = 0;
        #1;
        check_bit("tick blocks cmd_ready", cmd_ready, 0);
        step();
        drop_tick = 0; cmd_valid = 0;
        check_num("gravity cand x", int'(chk_t.coordinate.x), 3);
        check_num("gravity cand y", int'(chk_t.coordinate.y), 2);
        merge_f = p1;
        step();
        check_bit("lock busy", busy, 1);
        check_bit("lock clean_enable", clean_enable, 0);
        check_num("lock cur y", int'(cur.coordinate.y), 1);
        step();
        check_field("merge field", field, p1);
        check_bit("clean_enable on", clean_enable, 1);
        for (int i = 0; i < 3; i++) begin
            drop_tick = 1; step();
            drop_tick = 0; step();
            check_bit("clean_enable held", clean_enable, 1);
            check_field("field stable in clean", field, p1);
        end
        clean_done = 1; clean_lines = 3'd1; clean_f = p2;
        step();
        clean_done = 0;
        check_field("cleaned field", field, p2);
        check_num("lines after 1", int'(lines_total), 1);
        check_bit("clean_enable off", clean_enable, 0);
        spawn_piece = t2_raw; chk_ok = 1;
        step(); step();
        check_piece("respawn cur", cur, exp2);
        check_bit("pending blocks cmd_ready", cmd_ready, 0);
        step(); step();
        check_num("one collapsed tick", int'(cur.coordinate.y), 1);
        check_bit("pending cleared", cmd_ready, 1);
        step(); step();
        check_num("no second tick", int'(cur.coordinate.y), 1);

        // hard drop from row 1, five free rows
        cmd_valid = 1; cmd = 3'd4; chk_ok = 1;
        step();
        cmd_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            check_num($sformatf("hard cand y%0d", k), int'(chk_t.coordinate.y), 1 + k);
            step();
            check_num($sformatf("hard cur y%0d", k), int'(cur.coordinate.y), 1 + k);
        end
        chk_ok = 0; merge_f = p3;
        step();
        check_bit("hard lock busy", busy, 1);
        check_num("hard final y", int'(cur.coordinate.y), 6);
        step();
        check_field("hard merge field", field, p3);
        check_bit("hard clean_enable", clean_enable, 1);

        // saturation, seen on the 3-bit instance
        clean_done = 1; clean_lines = 3'd4; clean_f = p4;
        step(); clean_done = 0;
        check_num("lines 5", int'(lines_total), 5);
        check_num("small lines 5", int'(s_lines), 5);
        go_clean(p1);
        clean_done = 1; clean_lines = 3'd4; clean_f = p2;
        step(); clean_done = 0;
        check_num("lines 9", int'(lines_total), 9);
        check_num("small lines sat", int'(s_lines), 7);
        go_clean(p3);
        clean_done = 1; clean_lines = 3'd4;
        step(); clean_done = 0;
        check_num("lines 13", int'(lines_total), 13);
        check_num("small lines stays sat", int'(s_lines), 7);

        // start in the middle of CLEAN
        go_clean(p2);
        check_bit("mid clean enable", clean_enable, 1);
        start = 1; step(); start = 0;
        check_bit("start drops clean_enable", clean_enable, 0);
        check_field("start empties field", field, '1);
        check_num("start clears lines", int'(lines_total), 0);
        check_num("start clears small lines", int'(s_lines), 0);

        // game over: spawn of t_raw blocked, cur stays the previous piece
        spawn_piece = t_raw; chk_ok = 0;
        step(); step();
        check_bit("over game_over", game_over, 1);
        check_bit("over busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd = 3'd1; drop_tick = 1; merge_f = p1; clean_done = 1; chk_ok = 1;
            #1;
            check_bit("over cmd_ready", cmd_ready, 0);
            step();
            check_piece("over cur frozen", cur, exp2);
            check_field("over field frozen", field, '1);
            check_bit("over stays", game_over, 1);
            check_piece("over cand frozen", chk_t, exp1);
        end
        clear_inputs();
        start = 1; step(); start = 0;
        check_bit("restart game_over", game_over, 0);
        check_num("restart lines", int'(lines_total), 0);
        chk_ok = 1; step();
        check_bit("restart spawn_ack", spawn_ack, 1);
        step();
        check_piece("restart cur", cur, exp1);
        check_bit("restart ready", busy, 0);

        // asynchronous reset mid-game
        clean_done = 0; clean_lines = 3'd2;
        go_clean(p4);
        check_field("pre-reset field", field, p4);
        #2 rst = 0;
        #1;
        check_field("async rst field", field, '1);
        check_piece("async rst cur", cur, '0);
        check_piece("async rst chk_t", chk_t, '0);
        check_bit("async rst clean_enable", clean_enable, 0);
        check_bit("async rst busy", busy, 0);
        check_bit("async rst game_over", game_over, 0);
        step();

        // random play against the model
        clear_inputs();
        model_reset();
        rst = 1;
        for (int n = 0; n < 2000; n++) begin
            start = ($urandom_range(0, 199) == 0) ||
                    ((ph == P_IDLE || ph == P_OVER) && ($urandom_range(0, 7) == 0));
            drop_tick   = ($urandom_range(0, 5) == 0);
            cmd_valid   = $urandom_range(0, 1);
            cmd         = 3'($urandom_range(0, 7));
            chk_ok      = ($urandom_range(0, 3) != 0);
            clean_done  = ($urandom_range(0, 2) == 0);
            clean_lines = 3'($urandom_range(0, 4));
            w           = $urandom;
            spawn_piece = w[30:0];
            merge_f     = rand_field();
            clean_f     = rand_field();
            #1;
            check_bit("rnd cmd_ready", cmd_ready, ph == P_READY && !drop_tick && !m_pend);
            check_bit("rnd busy", busy, !(ph == P_READY || ph == P_IDLE));
            check_bit("rnd small cmd_ready", s_ready, ph == P_READY && !drop_tick && !m_pend);
            check_bit("rnd small busy", s_busy, !(ph == P_READY || ph == P_IDLE));
            model_step();
            step();
            check_piece("rnd cur", cur, m_cur);
            check_piece("rnd chk_t", chk_t, m_cand);
            check_field("rnd field", field, m_field);
            check_field("rnd chk_f", chk_f, m_field);
            check_num("rnd lines", int'(lines_total), (m_lines > 65535) ? 65535 : m_lines);
            check_num("rnd small lines", int'(s_lines), (m_lines > 7) ? 7 : m_lines);
            check_bit("rnd game_over", game_over, m_over);
            check_bit("rnd clean_enable", clean_enable, m_ce);
            check_bit("rnd spawn_ack", spawn_ack, m_ack);
            check_piece("rnd small cur", s_cur, m_cur);
            check_piece("rnd small chk_t", s_chk_t, m_cand);
            check_field("rnd small field", s_field, m_field);
            check_field("rnd small chk_f", s_chk_f, m_field);
            check_bit("rnd small over", s_over, m_over);
            check_bit("rnd small ce", s_ce, m_ce);
            check_bit("rnd small ack", s_ack, m_ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
